// File: rtl/x87_pkg.sv
// x87_pkg: command codes shared by x87_exec, x87_decode and the memory
// sequencer, plus memstore size codes, writeback kinds and a bus helper.
package x87_pkg;

  // Command encoding. This is the single definition used by every x87 block.
  localparam logic [4:0] CMD_NOP       = 5'd0;
  localparam logic [4:0] CMD_FLD_STI   = 5'd1;
  localparam logic [4:0] CMD_FXCH      = 5'd2;
  localparam logic [4:0] CMD_FADD_STI  = 5'd3;
  localparam logic [4:0] CMD_FSUB_STI  = 5'd4;
  localparam logic [4:0] CMD_FMUL_STI  = 5'd5;
  localparam logic [4:0] CMD_FDIV_STI  = 5'd6;
  localparam logic [4:0] CMD_FCHS      = 5'd7;
  localparam logic [4:0] CMD_FABS      = 5'd8;
  localparam logic [4:0] CMD_FLDZ      = 5'd9;
  localparam logic [4:0] CMD_FLD1      = 5'd10;
  localparam logic [4:0] CMD_FCOM_STI  = 5'd11;
  localparam logic [4:0] CMD_FNSTSW_AX = 5'd12;
  localparam logic [4:0] CMD_FINIT     = 5'd13;
  localparam logic [4:0] CMD_FLD_M32   = 5'd16;
  localparam logic [4:0] CMD_FLD_M64   = 5'd17;
  localparam logic [4:0] CMD_FSTP_M32  = 5'd18;
  localparam logic [4:0] CMD_FSTP_M64  = 5'd19;
  localparam logic [4:0] CMD_FLDCW     = 5'd20;
  localparam logic [4:0] CMD_FNSTCW    = 5'd21;

  // Memstore size codes reported by x87_exec.
  localparam logic [1:0] MS_SIZE_16 = 2'd0;
  localparam logic [1:0] MS_SIZE_32 = 2'd1;
  localparam logic [1:0] MS_SIZE_64 = 2'd2;

  // Writeback kinds reported by x87_exec.
  localparam logic [2:0] WB_NONE       = 3'd0;
  localparam logic [2:0] WB_AX_STATUS  = 3'd1;
  localparam logic [2:0] WB_AX_CONTROL = 3'd2;

  // Bus addresses are always word aligned; byte lanes are selected by mem_be.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/x87_cmd_class.sv
// x87_cmd_class: combinational decode of a command code into its memory
// class and the address bits that must be zero for it.
module x87_cmd_class
  import x87_pkg::*;
(
  input  logic [4:0] cmd,
  output logic       is_load16,
  output logic       is_load32,
  output logic       is_load64,
  output logic       is_store,
  output logic [1:0] align_mask
);

  // Classify the command; register-only codes fall through with all flags low.
  always_comb begin
    is_load16  = 1'b0;
    is_load32  = 1'b0;
    is_load64  = 1'b0;
    is_store   = 1'b0;
    align_mask = 2'b00;
    case (cmd)
      CMD_FLDCW: begin
        is_load16  = 1'b1;
        align_mask = 2'b01;
      end
      CMD_FLD_M32: begin
        is_load32  = 1'b1;
        align_mask = 2'b11;
      end
      CMD_FLD_M64: begin
        is_load64  = 1'b1;
        align_mask = 2'b11;
      end
      CMD_FNSTCW: begin
        is_store   = 1'b1;
        align_mask = 2'b01;
      end
      CMD_FSTP_M32, CMD_FSTP_M64: begin
        is_store   = 1'b1;
        align_mask = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/x87_mem_sequencer.sv
// x87_mem_sequencer: accepts one x87 command at a time, fetches its memory
// operand, starts x87_exec, writes back any memstore result and reports
// completion to the pipeline.
// Optional feature macro: X87_MEM_TIMEOUT_EN (per-beat mem_ack timeout).
//
// Handshakes:
//  - req: a command transfers on a cycle where req_valid && req_ready;
//    req_ready is high only in IDLE and req_valid is ignored elsewhere.
//  - cpl: cpl_valid is a one-cycle pulse with no backpressure; cpl_err and
//    cpl_wb_* qualify it.
//  - mem: mem_req and its qualifiers are held stable until the cycle mem_ack
//    is high (which may be the first request cycle); that cycle ends the beat.
//  - exec: x_start and x_cmd_valid pulse together for one cycle; x_done
//    (with memstore_* and wb_*) is taken on any later cycle while waiting.
module x87_mem_sequencer
  import x87_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cmd,
  input  logic [2:0]  req_idx,
  input  logic [31:0] req_addr,
  output logic        cpl_valid,
  output logic        cpl_err,
  output logic        cpl_wb_valid,
  output logic [2:0]  cpl_wb_kind,
  output logic [15:0] cpl_wb_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        x_start,
  output logic        x_cmd_valid,
  output logic [4:0]  x_cmd,
  output logic [2:0]  x_idx,
  output logic [31:0] x_rdata32,
  output logic [63:0] x_rdata64,
  input  logic        x_done,
  input  logic        x_memstore_valid,
  input  logic [1:0]  x_memstore_size,
  input  logic [63:0] x_memstore_data64,
  input  logic        x_wb_valid,
  input  logic [2:0]  x_wb_kind,
  input  logic [15:0] x_wb_value,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LD0  = 4'd1,
    S_LD1  = 4'd2,
    S_EXEC = 4'd3,
    S_WAIT = 4'd4,
    S_ST0  = 4'd5,
    S_ST1  = 4'd6,
    S_CPL  = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        ld16_q;
  logic        ld64_q;
  logic [1:0]  ms_size_q;
  logic [63:0] ms_data_q;

  logic        c_load16;
  logic        c_load32;
  logic        c_load64;
  logic        c_store;
  logic [1:0]  c_align_mask;
  logic        c_is_load;
  logic        c_misaligned;
  logic        timeout_hit;

  x87_cmd_class u_cmd_class (
    .cmd        (req_cmd),
    .is_load16  (c_load16),
    .is_load32  (c_load32),
    .is_load64  (c_load64),
    .is_store   (c_store),
    .align_mask (c_align_mask)
  );

  assign c_is_load    = c_load16 | c_load32 | c_load64;
  // Only memory commands carry an address that can be misaligned.
  assign c_misaligned = (c_is_load | c_store) && ((req_addr[1:0] & c_align_mask) != 2'b00);

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

`ifdef X87_MEM_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        in_beat;

  assign in_beat     = (state == S_LD0) || (state == S_LD1) ||
                       (state == S_ST0) || (state == S_ST1);
  assign timeout_hit = in_beat && !mem_ack && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Count consecutive cycles of the current beat without mem_ack.
  always_ff @(posedge clk) begin
    if (rst || !in_beat || mem_ack || timeout_hit) begin
      to_cnt <= 16'd0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencer FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= 32'd0;
      ld16_q       <= 1'b0;
      ld64_q       <= 1'b0;
      ms_size_q    <= MS_SIZE_16;
      ms_data_q    <= 64'd0;
      cpl_valid    <= 1'b0;
      cpl_err      <= 1'b0;
      cpl_wb_valid <= 1'b0;
      cpl_wb_kind  <= WB_NONE;
      cpl_wb_value <= 16'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
      x_start      <= 1'b0;
      x_cmd_valid  <= 1'b0;
      x_cmd        <= CMD_NOP;
      x_idx        <= 3'd0;
      x_rdata32    <= 32'd0;
      x_rdata64    <= 64'd0;
    end else begin
      x_start     <= 1'b0;
      x_cmd_valid <= 1'b0;
      cpl_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            x_cmd        <= req_cmd;
            x_idx        <= req_idx;
            addr_q       <= req_addr;
            ld16_q       <= c_load16;
            ld64_q       <= c_load64;
            cpl_err      <= 1'b0;
            cpl_wb_valid <= 1'b0;
            cpl_wb_kind  <= WB_NONE;
            cpl_wb_value <= 16'd0;
            if (c_misaligned) begin
              cpl_valid <= 1'b1;
              cpl_err   <= 1'b1;
              state     <= S_ERR;
            end else if (c_is_load) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= word_addr(req_addr);
              mem_be    <= 4'hF;
              mem_wdata <= 32'd0;
              state     <= S_LD0;
            end else begin
              x_start     <= 1'b1;
              x_cmd_valid <= 1'b1;
              state       <= S_EXEC;
            end
          end
        end

        S_LD0: begin
          if (timeout_hit) begin
            mem_req   <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_err   <= 1'b1;
            state     <= S_ERR;
          end else if (mem_ack) begin
            if (ld64_q) begin
              // Second beat follows immediately; mem_req stays asserted.
              x_rdata64[31:0] <= mem_rdata;
              mem_addr        <= word_addr(addr_q + 32'd4);
              state           <= S_LD1;
            end else begin
              if (ld16_q) begin
                x_rdata32 <= {16'd0, addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
              end else begin
                x_rdata32 <= mem_rdata;
              end
              mem_req     <= 1'b0;
              x_start     <= 1'b1;
              x_cmd_valid <= 1'b1;
              state       <= S_EXEC;
            end
          end
        end

        S_LD1: begin
          if (timeout_hit) begin
            mem_req   <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_err   <= 1'b1;
            state     <= S_ERR;
          end else if (mem_ack) begin
            x_rdata64[63:32] <= mem_rdata;
            mem_req          <= 1'b0;
            x_start          <= 1'b1;
            x_cmd_valid      <= 1'b1;
            state            <= S_EXEC;
          end
        end

        S_EXEC: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (x_done) begin
            cpl_wb_valid <= x_wb_valid;
            cpl_wb_kind  <= x_wb_kind;
            cpl_wb_value <= x_wb_value;
            ms_size_q    <= x_memstore_size;
            ms_data_q    <= x_memstore_data64;
            if (x_memstore_valid) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= word_addr(addr_q);
              if (x_memstore_size == MS_SIZE_16) begin
                // A 16-bit store lands in whichever half addr[1] selects.
                mem_be    <= addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata <= {2{x_memstore_data64[15:0]}};
              end else begin
                mem_be    <= 4'hF;
                mem_wdata <= x_memstore_data64[31:0];
              end
              state <= S_ST0;
            end else begin
              cpl_valid <= 1'b1;
              state     <= S_CPL;
            end
          end
        end

        S_ST0: begin
          if (timeout_hit) begin
            mem_req   <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_err   <= 1'b1;
            state     <= S_ERR;
          end else if (mem_ack) begin
            if (ms_size_q == MS_SIZE_64) begin
              mem_addr  <= word_addr(addr_q + 32'd4);
              mem_be    <= 4'hF;
              mem_wdata <= ms_data_q[63:32];
              state     <= S_ST1;
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              cpl_valid <= 1'b1;
              state     <= S_CPL;
            end
          end
        end

        S_ST1: begin
          if (timeout_hit) begin
            mem_req   <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_err   <= 1'b1;
            state     <= S_ERR;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpl_valid <= 1'b1;
            state     <= S_CPL;
          end
        end

        S_CPL, S_ERR: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
